// File: rtl/panel_pkg.sv
// panel_pkg
//   Shared definitions for the panel input controller: the run-control
//   state encoding and the default debounce timing.
//   No ports.
package panel_pkg;

  // Encoding is fixed; the fourth code (3) is illegal and recovers to HALT.
  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_RUN  = 2'd1,
    ST_STEP = 2'd2
  } state_t;

  // 20 ms at 50 MHz.
  localparam int DEB_CYCLES_DEF = 1_000_000;
  localparam int CNT_W_DEF      = 20;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit
//   One input bit: 2-FF synchroniser followed by a debounce counter and a
//   stable-value register. The output is in "asserted = 1" polarity: the
//   synchronised level is XORed with IDLE, so an active-low key (IDLE = 1)
//   reads 1 when pressed.
// Ports
//   clk   in  system clock
//   rst   in  synchronous active-high reset
//   din   in  raw asynchronous pin level
//   dout  out debounced level, 0 at idle
module debounce_bit
  import panel_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter bit IDLE       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             meta_q;
  logic             sync_q;
  logic [CNT_W-1:0] cnt_q;
  logic             stable_q;
  logic             lvl;

  assign lvl = sync_q ^ IDLE;

  // Any cycle where the synchronised level agrees with the stable value
  // throws away the partial count, so a bounce shorter than DEB_CYCLES
  // never reaches the output.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q   <= IDLE;
      sync_q   <= IDLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      if (lvl == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= lvl;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/panel_input_ctrl.sv
// panel_input_ctrl
//   Debounces board switches and push-keys and turns key presses into
//   run / halt / single-step control of the divided CPU clock.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   HALT  | CPU stopped, cpu_en = 0
//   RUN   | CPU free-running, cpu_en = 1, running = 1
//   STEP  | cpu_en = 1 until the next tick, then back to HALT
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   sw_raw     in   raw switches, 1 = on
//   key_raw    in   raw keys, 0 = pressed (key[0] run/halt, key[1] step)
//   tick       in   one-clk strobe per divided CPU clock period
//   sw         out  debounced switch levels
//   key_level  out  debounced key levels, 1 = pressed
//   key_press  out  one-clk pulse per accepted press
//   cpu_en     out  CPU clock-enable
//   running    out  1 while in RUN
module panel_input_ctrl
  import panel_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter bit RESET_RUN  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw_raw,
  input  logic [1:0] key_raw,
  input  logic       tick,
  output logic [1:0] sw,
  output logic [1:0] key_level,
  output logic [1:0] key_press,
  output logic       cpu_en,
  output logic       running
);

  localparam state_t ST_RESET = RESET_RUN ? ST_RUN : ST_HALT;

  for (genvar i = 0; i < 2; i++) begin : g_in
    debounce_bit #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W),
      .IDLE       (1'b0)
    ) u_sw (
      .clk  (clk),
      .rst  (rst),
      .din  (sw_raw[i]),
      .dout (sw[i])
    );

    debounce_bit #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W),
      .IDLE       (1'b1)
    ) u_key (
      .clk  (clk),
      .rst  (rst),
      .din  (key_raw[i]),
      .dout (key_level[i])
    );
  end

  logic [1:0] key_level_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      key_level_q <= '0;
      key_press   <= '0;
    end else begin
      key_level_q <= key_level;
      key_press   <= key_level & ~key_level_q;
    end
  end

  state_t state_q;
  state_t state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RESET;
    end else begin
      state_q <= state_d;
    end
  end

  // key[0] is checked first everywhere so it wins over key[1] and over tick.
  always_comb begin
    state_d = state_q;
    cpu_en  = 1'b0;
    running = 1'b0;
    case (state_q)
      ST_RUN: begin
        cpu_en  = 1'b1;
        running = 1'b1;
        if (key_press[0]) state_d = ST_HALT;
      end
      ST_HALT: begin
        if (key_press[0])      state_d = ST_RUN;
        else if (key_press[1]) state_d = ST_STEP;
      end
      ST_STEP: begin
        cpu_en = 1'b1;
        if (key_press[0]) state_d = ST_RUN;
        else if (tick)    state_d = ST_HALT;
      end
      default: state_d = ST_HALT;
    endcase
  end

endmodule

// File: tb/tb_panel_input_ctrl.sv
// tb_panel_input_ctrl
//   Directed stimulus for panel_input_ctrl with DEB_CYCLES = 4, CNT_W = 3 and
//   a tick every 8 clk. Stimulus pushes (cycle, signal, value) expectations
//   into a queue; a monitor on the falling edge pops and compares them.
module tb_panel_input_ctrl;
  import panel_pkg::*;

  localparam int SIG_SW      = 0;
  localparam int SIG_KLVL    = 1;
  localparam int SIG_KPRS    = 2;
  localparam int SIG_CPUEN   = 3;
  localparam int SIG_RUN     = 4;
  localparam int SIG_NPRESS0 = 5;
  localparam int SIG_NENTICK = 6;

  typedef struct {
    int    cyc;
    int    sig;
    int    val;
    string name;
  } exp_t;

  exp_t exp_q[$];

  logic       clk     = 1'b0;
  logic       rst     = 1'b1;
  logic [1:0] sw_raw  = 2'b00;
  logic [1:0] key_raw = 2'b11;
  logic       tick    = 1'b0;
  logic [1:0] sw;
  logic [1:0] key_level;
  logic [1:0] key_press;
  logic       cpu_en;
  logic       running;

  int cyc       = 0;
  int n_cmp     = 0;
  int n_fail    = 0;
  int n_press0  = 0;
  int n_en_tick = 0;
  int mon_act;
  bit win       = 1'b0;

  panel_input_ctrl #(
    .DEB_CYCLES (4),
    .CNT_W      (3),
    .RESET_RUN  (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_raw    (sw_raw),
    .key_raw   (key_raw),
    .tick      (tick),
    .sw        (sw),
    .key_level (key_level),
    .key_press (key_press),
    .cpu_en    (cpu_en),
    .running   (running)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int sample(input int sig);
    case (sig)
      SIG_SW:      return int'(sw);
      SIG_KLVL:    return int'(key_level);
      SIG_KPRS:    return int'(key_press);
      SIG_CPUEN:   return int'(cpu_en);
      SIG_RUN:     return int'(running);
      SIG_NPRESS0: return n_press0;
      SIG_NENTICK: return n_en_tick;
      default:     return -1;
    endcase
  endfunction

  // Monitor: counts events, then checks every expectation due this cycle.
  always @(negedge clk) begin
    if (key_press[0]) n_press0 = n_press0 + 1;
    if (win && tick && cpu_en) n_en_tick = n_en_tick + 1;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc <= cyc) begin
        n_cmp = n_cmp + 1;
        mon_act = sample(exp_q[i].sig);
        if (exp_q[i].cyc < cyc) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: check for cycle %0d missed (now %0d)", exp_q[i].name, exp_q[i].cyc, cyc);
        end else if (mon_act != exp_q[i].val) begin
          n_fail = n_fail + 1;
          $display("FAIL %s at cycle %0d: got %0d, want %0d", exp_q[i].name, cyc, mon_act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      tick = (cyc % 8 == 0);
    end
  endtask

  task automatic exp_at(input int k, input int sig, input int val, input string name);
    exp_t e;
    e.cyc  = cyc + k;
    e.sig  = sig;
    e.val  = val;
    e.name = name;
    exp_q.push_back(e);
  endtask

  // Press key[0] alone, hold 20 cycles, release and let it settle.
  task automatic toggle_run(input int want_running);
    key_raw[0] = 1'b0;
    exp_at(7, SIG_KPRS, 1, "k0_press");
    exp_at(8, SIG_RUN, want_running, "k0_running");
    exp_at(8, SIG_CPUEN, want_running, "k0_cpu_en");
    step(20);
    key_raw[0] = 1'b1;
    step(10);
  endtask

  initial begin
    // 1: reset values, then reset in the middle of a debounce count
    rst = 1'b1;
    step(2);
    exp_at(0, SIG_SW, 0, "rst_sw");
    exp_at(0, SIG_KLVL, 0, "rst_key_level");
    exp_at(0, SIG_KPRS, 0, "rst_key_press");
    exp_at(0, SIG_CPUEN, 1, "rst_cpu_en");
    exp_at(0, SIG_RUN, 1, "rst_running");
    step(1);
    rst = 1'b0;
    sw_raw[1] = 1'b1;
    step(4);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    exp_at(0, SIG_RUN, 1, "rst_mid_state");
    for (int k = 0; k < 6; k++) exp_at(k, SIG_SW, 0, "rst_mid_sw_hold");
    exp_at(6, SIG_SW, 2, "rst_mid_recount");
    step(8);
    sw_raw[1] = 1'b0;
    exp_at(6, SIG_SW, 0, "sw1_fall");
    step(8);

    // 2: clean edge latency, then bounce
    sw_raw[0] = 1'b1;
    exp_at(5, SIG_SW, 0, "sw0_not_early");
    exp_at(6, SIG_SW, 1, "sw0_rise_6");
    step(8);
    sw_raw[0] = 1'b0;
    exp_at(6, SIG_SW, 0, "sw0_fall");
    step(8);
    for (int r = 0; r < 6; r++) begin
      sw_raw[0] = 1'b1;
      exp_at(0, SIG_SW, 0, "bounce_sw");
      step(1);
      exp_at(0, SIG_SW, 0, "bounce_sw");
      step(1);
      sw_raw[0] = 1'b0;
      exp_at(0, SIG_SW, 0, "bounce_sw");
      step(1);
    end
    for (int k = 0; k < 8; k++) exp_at(k, SIG_SW, 0, "bounce_tail");
    step(8);

    // 3: key[0] held 20 cycles in RUN -> HALT, single pulse, none on release
    key_raw[0] = 1'b0;
    exp_at(5, SIG_KLVL, 0, "k0_level_not_early");
    exp_at(6, SIG_KLVL, 1, "k0_level_6");
    exp_at(6, SIG_KPRS, 0, "k0_press_not_early");
    exp_at(7, SIG_KPRS, 1, "k0_press_7");
    exp_at(8, SIG_KPRS, 0, "k0_press_one_cycle");
    exp_at(7, SIG_CPUEN, 1, "k0_cpu_en_before");
    exp_at(8, SIG_CPUEN, 0, "k0_halt_cpu_en");
    exp_at(8, SIG_RUN, 0, "k0_halt_running");
    step(20);
    key_raw[0] = 1'b1;
    exp_at(5, SIG_KLVL, 1, "k0_release_not_early");
    exp_at(6, SIG_KLVL, 0, "k0_release_level");
    for (int k = 6; k < 10; k++) exp_at(k, SIG_KPRS, 0, "k0_release_no_pulse");
    step(10);
    exp_at(0, SIG_NPRESS0, 1, "k0_pulse_count");
    exp_at(0, SIG_CPUEN, 0, "k0_still_halt");

    // 4: single step from HALT; the tick on the accept cycle does not count
    while ((cyc + 7) % 8 != 0) step(1);
    win = 1'b1;
    key_raw[1] = 1'b0;
    exp_at(7, SIG_KPRS, 2, "k1_press");
    exp_at(7, SIG_CPUEN, 0, "step_pre");
    exp_at(8, SIG_CPUEN, 1, "step_enter");
    exp_at(8, SIG_RUN, 0, "step_running");
    exp_at(15, SIG_CPUEN, 1, "step_hold_to_tick");
    exp_at(16, SIG_CPUEN, 0, "step_done");
    exp_at(16, SIG_RUN, 0, "step_done_running");
    exp_at(19, SIG_NENTICK, 1, "step_one_tick");
    step(20);
    win = 1'b0;
    key_raw[1] = 1'b1;
    step(10);
    toggle_run(1);
    key_raw[1] = 1'b0;
    exp_at(7, SIG_KPRS, 2, "k1_in_run_press");
    exp_at(8, SIG_RUN, 1, "k1_in_run_ignored");
    exp_at(16, SIG_CPUEN, 1, "k1_in_run_cpu_en");
    step(20);
    key_raw[1] = 1'b1;
    step(10);

    // 5: key priority
    toggle_run(0);
    key_raw = 2'b00;
    exp_at(7, SIG_KPRS, 3, "both_press");
    exp_at(8, SIG_RUN, 1, "both_to_run");
    exp_at(8, SIG_CPUEN, 1, "both_cpu_en");
    exp_at(12, SIG_RUN, 1, "both_stays_run");
    step(20);
    key_raw = 2'b11;
    step(10);
    toggle_run(0);
    while (cyc % 8 != 0) step(1);
    key_raw[1] = 1'b0;
    exp_at(8, SIG_RUN, 0, "step_then_k0_in_step");
    exp_at(8, SIG_CPUEN, 1, "step_then_k0_step_en");
    exp_at(9, SIG_RUN, 1, "k0_beats_tick");
    exp_at(9, SIG_CPUEN, 1, "k0_beats_tick_en");
    exp_at(14, SIG_RUN, 1, "k0_in_step_stays_run");
    step(1);
    key_raw[0] = 1'b0;
    step(20);
    key_raw = 2'b11;
    step(10);

    // 6: illegal state code recovers to HALT
    force dut.state_q = state_t'(2'd3);
    #2;
    release dut.state_q;
    exp_at(0, SIG_CPUEN, 0, "illegal_cpu_en");
    exp_at(0, SIG_RUN, 0, "illegal_running");
    exp_at(1, SIG_CPUEN, 0, "recover_cpu_en");
    exp_at(1, SIG_RUN, 0, "recover_running");
    exp_at(3, SIG_CPUEN, 0, "recover_stays_halt");
    step(4);
    toggle_run(1);

    step(5);
    while (exp_q.size() > 0) begin
      n_cmp  = n_cmp + 1;
      n_fail = n_fail + 1;
      $display("FAIL %s: never checked (due cycle %0d)", exp_q[0].name, exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
